karatsuba32_seq_ctrl: RTL and testbench
=======================================

KARATSUBA32_SEQ_CTRL -- requirements
Module: karatsuba32_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand width; 32 is the only supported value.
REQ-002 SHALL have parameter H, default N/2 (16), meaning half-operand width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; it is asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning the operand pair is valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the controller accepts operands.
REQ-007 SHALL have ports x and y, each input, N bits, the unsigned operands.
REQ-008 SHALL have ports mul_a and mul_b, each output, 18 bits, the operands driven to the shared combinational 18x18 unsigned Booth multiplier.
REQ-009 SHALL have port mul_p, input, 36 bits, the product returned from the shared multiplier in the same cycle.
REQ-010 SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-011 SHALL have port out_ready, input, 1, meaning the downstream consumer accepts the result.
REQ-012 SHALL have port p, output, 2N bits, the unsigned product x*y.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, M0, M1, M2, COMB and DONE.
REQ-015 SHALL assert in_ready only in IDLE; in_valid&in_ready registers x and y and moves the FSM to M0.
REQ-016 SHALL split the registered operands as xh=x[31:16], xl=x[15:0], yh=y[31:16], yl=y[15:0].
REQ-017 SHALL, in M0, drive mul_a={2'b0,xl} and mul_b={2'b0,yl}, capture z0=mul_p[31:0] at the edge, and move to M1.
REQ-018 SHALL, in M1, drive mul_a={2'b0,xh} and mul_b={2'b0,yh}, capture z2=mul_p[31:0], and move to M2.
REQ-019 SHALL, in M2, drive mul_a={1'b0,xh+xl} and mul_b={1'b0,yh+yl} (17-bit sums, no truncation), capture z1=mul_p[33:0], and move to COMB.
REQ-020 SHALL drive mul_a and mul_b to 0 in IDLE, COMB and DONE.
REQ-021 SHALL, in COMB, compute mid=z1-z2-z0 as a 34-bit non-negative value, register p=(z2<<32)+(mid<<16)+z0 at full 64-bit width with no overflow, and move to DONE.
REQ-022 SHALL assert out_valid in DONE with p stable; out_valid&out_ready returns the FSM to IDLE.
REQ-023 SHALL hold p and out_valid unchanged in DONE while out_ready is low, with no timeout.
REQ-024 SHALL give a latency of 5 cycles from the accepting edge to the first out_valid; back-to-back throughput is one result per 6 cycles when out_ready is held high.
REQ-025 SHALL ignore in_valid while busy; operands presented during a result handshake are accepted no earlier than the following cycle in IDLE.
REQ-026 SHALL retain p between operations; p changes only in COMB.
REQ-027 SHALL produce exact results for all inputs, including 0 and 0xFFFFFFFF operands, where z1 reaches 0x1FFFE*0x1FFFE.

Reset
REQ-028 SHALL, on rst assertion at any time including mid-operation, asynchronously force state=IDLE, in_ready=1 (after release), out_valid=0, busy=0, p=0, mul_a=0, mul_b=0, and clear the x, y, z0, z1 and z2 registers.
REQ-029 SHALL discard an aborted operation; no out_valid pulse is produced for it after reset release.
REQ-030 SHALL accept a new operand pair on the first rising edge after rst deasserts if in_valid is high.

Verification
REQ-031 SHALL cover: x=3, y=5, out_ready=1 -> out_valid 5 cycles after acceptance, p=0x000000000000000F.
REQ-032 SHALL cover: x=y=0xFFFFFFFF -> p=0xFFFFFFFE00000001, mul_a=mul_b=0x1FFFE observed in M2.
REQ-033 SHALL cover: x=y=0x00010000 -> p=0x0000000100000000; x=0, y=0xDEADBEEF -> p=0.
REQ-034 SHALL cover: out_ready low for 10 cycles in DONE -> out_valid and p stable, in_ready=0, a new in_valid ignored; out_ready high -> FSM returns to IDLE next cycle.
REQ-035 SHALL cover: rst pulsed during M1 -> out_valid=0 and busy=0 immediately; the next operation x=7, y=9 yields p=63 with no stale output.
REQ-036 SHALL cover: 10,000 random operand pairs with random out_ready backpressure -> every p equals the 64-bit reference product, and results appear in order.

Source files
------------

// File: rtl/karatsuba32_seq_ctrl.sv
// -----------------------------------------------------------------------------
// karatsuba32_seq_ctrl
//
// Sequential 32x32 -> 64 unsigned multiplier controller built on the Karatsuba
// decomposition. The three partial products are computed one per cycle on a
// single shared, purely combinational 18x18 multiplier that lives outside this
// block:
//   z0  = xl * yl
//   z2  = xh * yh
//   z1  = (xh + xl) * (yh + yl)      (17-bit sums, so up to 34-bit product)
//   p   = (z2 << 32) + ((z1 - z2 - z0) << 16) + z0
//
// Operation sequence: IDLE -> M0 -> M1 -> M2 -> COMB -> DONE -> IDLE.
// One result every 6 cycles when the consumer never stalls.
//
// Ports
//   clk        in   1    clock, all state on rising edge
//   rst        in   1    asynchronous, active-high reset
//   in_valid   in   1    operand pair x/y is valid
//   in_ready   out  1    controller can accept operands (IDLE only)
//   x, y       in   N    unsigned operands
//   mul_a      out  18   operand A to the shared multiplier
//   mul_b      out  18   operand B to the shared multiplier
//   mul_p      in   36   same-cycle product from the shared multiplier
//   out_valid  out  1    result p is valid (DONE)
//   out_ready  in   1    consumer accepts the result
//   p          out  2N   unsigned product x*y, held between operations
//   busy       out  1    controller is in any state other than IDLE
// -----------------------------------------------------------------------------
module karatsuba32_seq_ctrl #(
    parameter int N = 32,
    parameter int H = N / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     x,
    input  logic [N-1:0]     y,
    output logic [17:0]      mul_a,
    output logic [17:0]      mul_b,
    input  logic [35:0]      mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   p,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M0   = 3'd1,
        M1   = 3'd2,
        M2   = 3'd3,
        COMB = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Registered operands and partial products.
    logic [N-1:0]   r_x;
    logic [N-1:0]   r_y;
    logic [N-1:0]   r_z0;
    logic [N-1:0]   r_z2;
    logic [N+1:0]   r_z1;
    logic [2*N-1:0] r_p;

    // Half-word sums fed to the multiplier in M2; one extra bit keeps the carry.
    logic [H:0]     w_sum_x;
    logic [H:0]     w_sum_y;
    logic [N+1:0]   w_mid;
    logic [2*N-1:0] w_prod;

    // The top two product bits can never be set (max 0x1FFFE * 0x1FFFE fits
    // in 34 bits); they are folded here so the input stays fully consumed.
    logic           w_unused_mul_p;

    assign w_sum_x = {1'b0, r_x[N-1:H]} + {1'b0, r_x[H-1:0]};
    assign w_sum_y = {1'b0, r_y[N-1:H]} + {1'b0, r_y[H-1:0]};

    // z1 >= z2 + z0 always holds, so the 34-bit difference never wraps.
    assign w_mid  = r_z1 - {2'b00, r_z2} - {2'b00, r_z0};
    assign w_prod = {r_z2, {N{1'b0}}}
                  + {{(N-H-2){1'b0}}, w_mid, {H{1'b0}}}
                  + {{N{1'b0}}, r_z0};

    assign w_unused_mul_p = ^mul_p[35:34];

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        mul_a        = 18'd0;
        mul_b        = 18'd0;

        unique case (r_state)
            IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = M0;
                end
            end
            M0: begin
                mul_a        = {2'b00, r_x[H-1:0]};
                mul_b        = {2'b00, r_y[H-1:0]};
                w_next_state = M1;
            end
            M1: begin
                mul_a        = {2'b00, r_x[N-1:H]};
                mul_b        = {2'b00, r_y[N-1:H]};
                w_next_state = M2;
            end
            M2: begin
                mul_a        = {1'b0, w_sum_x};
                mul_b        = {1'b0, w_sum_y};
                w_next_state = COMB;
            end
            COMB: begin
                w_next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    // NOTE: the datapath registers are cleared by reset so a result aborted
    // mid-operation can never leak into p or a later computation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x  <= '0;
            r_y  <= '0;
            r_z0 <= '0;
            r_z1 <= '0;
            r_z2 <= '0;
            r_p  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x <= x;
                        r_y <= y;
                    end
                end
                M0:      r_z0 <= mul_p[N-1:0];
                M1:      r_z2 <= mul_p[N-1:0];
                M2:      r_z1 <= mul_p[N+1:0];
                COMB:    r_p  <= w_prod;
                default: ;
            endcase
        end
    end

    assign p = r_p;

endmodule

// File: tb/tb_karatsuba32_seq_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for karatsuba32_seq_ctrl. Provides the shared combinational
// multiplier, runs directed vectors with hand-computed products, backpressure
// and mid-operation reset scenarios, then a randomized stream checked against
// a 64-bit reference product queue.
// -----------------------------------------------------------------------------
module tb_karatsuba32_seq_ctrl;

    localparam int NRAND  = 10000;
    localparam int BUDGET = 7 * NRAND + 2000;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic [17:0] mul_a;
    logic [17:0] mul_b;
    logic [35:0] mul_p;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] p;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    karatsuba32_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    // Shared 18x18 unsigned multiplier, same-cycle result.
    assign mul_p = {18'd0, mul_a} * {18'd0, mul_b};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one operand pair with out_ready high. Reports in_ready at the
    // accepting edge, the cycle in which out_valid first appears (the cycle
    // starting at the accepting edge is cycle 1), p at that point, and the
    // multiplier operands seen in cycle 3 (M2).
    task automatic run_op(input logic [31:0] ax, input logic [31:0] ay,
                          output logic rdy, output int lat,
                          output logic [63:0] pv,
                          output logic [17:0] ma, output logic [17:0] mb);
        x         = ax;
        y         = ay;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        rdy       = in_ready;
        tick();
        in_valid = 1'b0;
        lat      = 1;
        ma       = '0;
        mb       = '0;
        while (!out_valid && lat < 20) begin
            if (lat == 3) begin
                ma = mul_a;
                mb = mul_b;
            end
            tick();
            lat++;
        end
        pv = p;
        tick();
    endtask

    logic        r_rdy;
    int          r_lat;
    logic [63:0] r_pv;
    logic [17:0] r_ma;
    logic [17:0] r_mb;
    logic [63:0] hold_exp;
    int          wait_cnt;
    logic [63:0] ref_q[$];
    logic [63:0] exp_p;
    logic        acc;
    logic        ret;
    int          sent;
    int          got;
    int          cyc;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        y         = '0;

        // Reset state
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_p",         p,              64'd0);
        check("rst_mul_a",     64'(mul_a),     64'd0);
        check("rst_mul_b",     64'(mul_b),     64'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // 3 * 5
        run_op(32'd3, 32'd5, r_rdy, r_lat, r_pv, r_ma, r_mb);
        check("small_accepted", 64'(r_rdy), 64'd1);
        check("small_latency",  64'(r_lat), 64'd5);
        check("small_p",        r_pv,       64'h0000_0000_0000_000F);
        check("small_idle_busy",   64'(busy),     64'd0);
        check("small_idle_ready",  64'(in_ready), 64'd1);
        check("small_p_retained",  p,             64'h0000_0000_0000_000F);

        // All-ones: the M2 operands reach their maximum 0x1FFFE
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, r_rdy, r_lat, r_pv, r_ma, r_mb);
        check("ones_p",       r_pv,       64'hFFFF_FFFE_0000_0001);
        check("ones_m2_a",    64'(r_ma),  64'h1FFFE);
        check("ones_m2_b",    64'(r_mb),  64'h1FFFE);
        check("ones_latency", 64'(r_lat), 64'd5);

        // 2^16 * 2^16: only z2 contributes; M2 sums are 1
        run_op(32'h0001_0000, 32'h0001_0000, r_rdy, r_lat, r_pv, r_ma, r_mb);
        check("pow16_p",    r_pv,      64'h0000_0001_0000_0000);
        check("pow16_m2_a", 64'(r_ma), 64'h00001);

        // Zero operand
        run_op(32'h0, 32'hDEAD_BEEF, r_rdy, r_lat, r_pv, r_ma, r_mb);
        check("zero_p", r_pv, 64'd0);

        // Backpressure: hold DONE for 10 cycles with a competing in_valid
        hold_exp  = 64'(32'h1234_5678) * 64'(32'h9ABC_DEF0);
        x         = 32'h1234_5678;
        y         = 32'h9ABC_DEF0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        check("bp_out_valid_rise", 64'(out_valid), 64'd1);
        check("bp_p",              p,              hold_exp);
        check("bp_done_mul_a",     64'(mul_a),     64'd0);
        x        = 32'h0000_0011;
        y        = 32'h0000_0022;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_p",     p,              hold_exp);
            check("bp_hold_ready", 64'(in_ready),  64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_busy",  64'(busy),      64'd0);
        check("bp_release_ready", 64'(in_ready),  64'd1);
        check("bp_release_p",     p,              hold_exp);

        // Reset while in M1, then an immediate new operation
        x        = 32'hAAAA_AAAA;
        y        = 32'h5555_5555;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("abort_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #2;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy",      64'(busy),      64'd0);
        check("abort_p",         p,              64'd0);
        check("abort_mul_a",     64'(mul_a),     64'd0);
        #2;
        rst = 1'b0;
        run_op(32'd7, 32'd9, r_rdy, r_lat, r_pv, r_ma, r_mb);
        check("after_abort_accepted", 64'(r_rdy), 64'd1);
        check("after_abort_latency",  64'(r_lat), 64'd5);
        check("after_abort_p",        r_pv,       64'd63);

        // Random stream with light backpressure, in-order scoreboard
        sent      = 0;
        got       = 0;
        cyc       = 0;
        x         = $urandom;
        y         = $urandom;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (got < NRAND && cyc < BUDGET) begin
            acc = in_valid && in_ready;
            ret = out_valid && out_ready;
            if (ret) begin
                exp_p = 'x;
                if (ref_q.size() > 0) begin
                    exp_p = ref_q.pop_front();
                end
                check("rand_p", p, exp_p);
                got++;
            end
            if (acc) begin
                ref_q.push_back(64'(x) * 64'(y));
            end
            tick();
            cyc++;
            if (acc) begin
                sent++;
                if (sent < NRAND) begin
                    x = $urandom;
                    y = $urandom;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(7) != 0);
        end
        check("rand_result_count", 64'(got), 64'(NRAND));
        check("rand_queue_empty",  64'(ref_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
